cmd_arb: RTL and testbench

Command arbiter sitting between the host command path (UART-side command receiver) and the command-configuration block. It shares the single command port of the configuration block between the host and an on-board link-loss failsafe. It issues one command at a time, waits for that command's response, and routes the response back to its originator. The failsafe injects an emergency-land command when the host falls silent while the motors are running.

---
 rtl/quad_pkg.sv | 27 ++
 rtl/cmd_arb_if.sv | 31 +++
 rtl/cmd_arb_sat_tmr.sv | 26 ++
 rtl/cmd_arb.sv | 129 ++++++++++++
 tb/tb_cmd_arb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared opcodes, response codes and arbiter enums
package quad_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;
  localparam logic [7:0] NAK       = 8'hEE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } arb_state_t;

  typedef enum logic {
    HOST,
    FS
  } owner_t;

endpackage

// File: rtl/cmd_arb_if.sv
// rtl/cmd_arb_if.sv - host and config-block command/response signals of the arbiter
interface cmd_arb_if;

  logic        host_rdy;
  logic [7:0]  host_cmd;
  logic [15:0] host_data;
  logic        clr_host_rdy;
  logic [7:0]  host_resp;
  logic        host_send_resp;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        motors_off;
  logic        link_lost;

  // Arbiter side
  modport master (
    input  host_rdy, host_cmd, host_data, clr_cmd_rdy, resp, send_resp, motors_off,
    output clr_host_rdy, host_resp, host_send_resp, cmd_rdy, cmd, data, link_lost
  );

  // Host / config-block side
  modport slave (
    output host_rdy, host_cmd, host_data, clr_cmd_rdy, resp, send_resp, motors_off,
    input  clr_host_rdy, host_resp, host_send_resp, cmd_rdy, cmd, data, link_lost
  );

endinterface

// File: rtl/cmd_arb_sat_tmr.sv
// rtl/cmd_arb_sat_tmr.sv - saturating up-counter with clear, flags all-ones
module sat_tmr #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [W-1:0] cnt;

  assign full = &cnt;

  // Count up while enabled, hold at all-ones, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !full)
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/cmd_arb.sv
// rtl/cmd_arb.sv - host/failsafe arbiter for the single config-block command port
module cmd_arb
  import quad_pkg::*;
#(
  parameter int TMO_W = 22,
  parameter int RSP_W = 20
) (
  input logic      clk,
  input logic      rst_n,
  cmd_arb_if.master bus
);

  arb_state_t  state;
  owner_t      owner;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        cmd_rdy_q;
  logic [7:0]  host_resp_q;
  logic        host_send_q;
  logic        link_lost_q;
  logic        motors_off_q;

  logic wd_full;
  logic rsp_full;
  logic fs_pend;
  logic fs_grant;
  logic host_grant;

  // One emergency-land per loss event: link_lost masks further requests
  assign fs_pend    = wd_full & ~bus.motors_off & ~link_lost_q;
  assign fs_grant   = (state == IDLE) & fs_pend;
  // Gated by rst_n so a held host_rdy cannot produce an ack while in reset
  assign host_grant = rst_n & (state == IDLE) & ~fs_pend & bus.host_rdy;

  assign bus.clr_host_rdy   = host_grant;
  assign bus.cmd_rdy        = cmd_rdy_q;
  assign bus.cmd            = cmd_q;
  assign bus.data           = data_q;
  assign bus.host_resp      = host_resp_q;
  assign bus.host_send_resp = host_send_q;
  assign bus.link_lost      = link_lost_q;

  // Link-loss watchdog: only runs with motors spinning, reset by host activity
  sat_tmr #(.W(TMO_W)) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.motors_off | host_grant),
    .en    (1'b1),
    .full  (wd_full)
  );

  // Response timeout: counts only while waiting for the config block
  sat_tmr #(.W(RSP_W)) u_rsp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != WAIT_RESP),
    .en    (state == WAIT_RESP),
    .full  (rsp_full)
  );

  // Arbitration FSM: grant, issue, wait for response, route it to the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= HOST;
      cmd_q       <= 8'h00;
      data_q      <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      host_resp_q <= 8'h00;
      host_send_q <= 1'b0;
    end else begin
      host_send_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fs_pend) begin
            owner     <= FS;
            cmd_q     <= EMER_LAND;
            data_q    <= 16'h0000;
            cmd_rdy_q <= 1'b1;
            state     <= ISSUE;
          end else if (bus.host_rdy) begin
            owner     <= HOST;
            cmd_q     <= bus.host_cmd;
            data_q    <= bus.host_data;
            cmd_rdy_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (bus.send_resp) begin
            if (owner == HOST) begin
              host_resp_q <= bus.resp;
              host_send_q <= 1'b1;
            end
            state <= IDLE;
          end else if (rsp_full) begin
            if (owner == HOST) begin
              host_resp_q <= NAK;
              host_send_q <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // link_lost: set by the failsafe grant, cleared by host grant or motors stopping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_lost_q  <= 1'b0;
      motors_off_q <= 1'b0;
    end else begin
      motors_off_q <= bus.motors_off;
      if (fs_grant)
        link_lost_q <= 1'b1;
      else if (host_grant || (bus.motors_off && !motors_off_q))
        link_lost_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
// tb/tb_cmd_arb.sv - directed scoreboard bench for cmd_arb
module tb_cmd_arb;
  import quad_pkg::*;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  int   last_wait;
  int   cnt;
  logic [8:0] sb_e;

  logic [23:0] exp_cmd[$];
  logic [7:0]  exp_resp[$];

  cmd_arb_if bus();

  cmd_arb #(.TMO_W(4), .RSP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Every host_send_resp pulse must match the next expected host response
  always @(negedge clk) begin
    if (bus.host_send_resp === 1'b1) begin
      sb_e = (exp_resp.size() != 0) ? {1'b1, exp_resp.pop_front()} : 9'h000;
      check("resp_scoreboard", {23'd0, 1'b1, bus.host_resp}, {23'd0, sb_e});
    end
  end

  task automatic wait_grant();
    int n = 0;
    #1;
    while (bus.clr_host_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("host_grant", bus.clr_host_rdy, 1);
  endtask

  task automatic host_go(input logic [7:0] c, input logic [15:0] d);
    exp_cmd.push_back({c, d});
    bus.host_rdy  = 1'b1;
    bus.host_cmd  = c;
    bus.host_data = d;
    wait_grant();
    @(negedge clk);
    bus.host_rdy = 1'b0;
  endtask

  task automatic issue_ack();
    int n = 0;
    logic [23:0] e;
    while (bus.cmd_rdy !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    check("cmd_rdy_seen", bus.cmd_rdy, 1);
    e = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : 24'hFFFFFF;
    check("cmd_data", {8'd0, bus.cmd, bus.data}, {8'd0, e});
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("cmd_rdy_drop", bus.cmd_rdy, 0);
  endtask

  task automatic respond(input int delay, input logic [7:0] r, input bit host);
    if (host) exp_resp.push_back(r);
    repeat (delay - 1) @(negedge clk);
    bus.send_resp = 1'b1;
    bus.resp      = r;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("send_pulse", bus.host_send_resp, host);
    if (host) check("host_resp", bus.host_resp, r);
    @(negedge clk);
    check("send_single", bus.host_send_resp, 0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    bus.host_rdy    = 1'b0;
    bus.host_cmd    = 8'h00;
    bus.host_data   = 16'h0000;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    bus.motors_off  = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus.cmd_rdy, bus.clr_host_rdy, bus.host_send_resp, bus.link_lost}, 0);
    check("rst_cmd_data", {bus.cmd, bus.data}, 0);
    check("rst_host_resp", bus.host_resp, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Host SET_PTCH, ack, response two cycles later
    host_go(SET_PTCH, 16'h1234);
    issue_ack();
    respond(2, POS_ACK, 1'b1);

    // Link loss: failsafe injects emergency-land, response swallowed
    bus.motors_off = 1'b0;
    exp_cmd.push_back({EMER_LAND, 16'h0000});
    issue_ack();
    check("wd_latency", last_wait, 16);
    check("link_lost_set", bus.link_lost, 1);
    respond(2, POS_ACK, 1'b0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.cmd_rdy) cnt++;
    end
    check("no_second_fs", cnt, 0);
    check("link_lost_hold", bus.link_lost, 1);

    // Failsafe and host request in the same cycle: failsafe first
    bus.motors_off = 1'b1;
    @(negedge clk);
    check("link_lost_mtrs_off", bus.link_lost, 0);
    bus.motors_off = 1'b0;
    repeat (15) @(negedge clk);
    exp_cmd.push_back({EMER_LAND, 16'h0000});
    exp_cmd.push_back({REQ_BATT, 16'h0000});
    bus.host_rdy  = 1'b1;
    bus.host_cmd  = REQ_BATT;
    bus.host_data = 16'h0000;
    #1;
    check("fs_wins_no_clr", bus.clr_host_rdy, 0);
    issue_ack();
    check("busy_no_clr", bus.clr_host_rdy, 0);
    check("link_lost_fs", bus.link_lost, 1);
    respond(2, POS_ACK, 1'b0);
    check("host_after_fs", bus.cmd_rdy, 1);
    check("link_lost_clr_grant", bus.link_lost, 0);
    bus.host_rdy = 1'b0;
    issue_ack();
    respond(2, 8'hC3, 1'b1);
    bus.motors_off = 1'b1;

    // Response timeout: NAK delivered to the host
    host_go(CALIBRATE, 16'h0000);
    issue_ack();
    exp_resp.push_back(NAK);
    cnt = 0;
    while (bus.host_send_resp !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("nak_latency_window", (cnt >= 31 && cnt <= 33), 1);
    check("nak_value", bus.host_resp, NAK);
    @(negedge clk);
    check("nak_idle", bus.cmd_rdy, 0);

    // Motors off: watchdog never injects
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cmd_rdy) cnt++;
    end
    check("mtrs_off_no_fs", cnt, 0);

    // Reset during WAIT_RESP, held host_rdy re-granted afterwards
    exp_cmd.push_back({SET_YAW, 16'hBEEF});
    bus.host_rdy  = 1'b1;
    bus.host_cmd  = SET_YAW;
    bus.host_data = 16'hBEEF;
    wait_grant();
    @(negedge clk);
    issue_ack();
    #1;
    check("held_rdy_busy", bus.clr_host_rdy, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {bus.cmd_rdy, bus.clr_host_rdy, bus.host_send_resp, bus.link_lost}, 0);
    check("async_rst_cmd", {bus.cmd, bus.data}, 0);
    check("async_rst_resp", bus.host_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cmd.push_back({SET_YAW, 16'hBEEF});
    wait_grant();
    @(negedge clk);
    bus.host_rdy = 1'b0;
    issue_ack();
    respond(1, POS_ACK, 1'b1);

    repeat (3) @(negedge clk);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
